// File: rtl/reg_access_master.sv
// reg_access_master: round-robin write/readback-verify master for the 16-bit register store.
// Two clients request writes; each grant runs WRITE, READ (RD_LAT cycles), CHECK, ACK.
module reg_access_master #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              req2,
    input  logic [DATA_W-1:0] data2,
    output logic              ack2,
    output logic              write_enable,
    output logic              read_enable,
    output logic [DATA_W-1:0] wr_data,
    output logic              src_sel,
    input  logic [DATA_W-1:0] rd_data,
    output logic              err_flag,
    output logic [7:0]        err_count,
    output logic [7:0]        txn_count
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, ACK} state_t;

    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic [DATA_W-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              src_q, src_d;
    logic              err_q, err_d;
    logic [7:0]        errc_q, errc_d;
    logic [7:0]        txn_q, txn_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              ack1_q, ack1_d;
    logic              ack2_q, ack2_d;
    logic              grant2;

    // prio_q = 1 means client 2 wins a tie
    assign grant2 = req2 && (!req1 || prio_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        src_d   = src_q;
        err_d   = err_q;
        errc_d  = errc_q;
        txn_d   = txn_q;
        case (state_q)
            IDLE: if (req1 || req2) begin
                src_d   = grant2;
                wr_d    = grant2 ? data2 : data1;
                state_d = WRITE;
            end
            WRITE: begin
                cnt_d   = CNT_INIT;
                state_d = READ;
            end
            READ: if (cnt_q == 4'd0) begin
                rd_d    = rd_data;
                state_d = CHECK;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            CHECK: begin
                err_d   = err_q || (rd_q != wr_q);
                errc_d  = (rd_q != wr_q && errc_q != 8'hFF) ? errc_q + 8'd1 : errc_q;
                txn_d   = txn_q + 8'd1;
                state_d = ACK;
            end
            ACK: begin
                prio_d  = !src_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // strobes are registered copies of the upcoming state so every output is a flop
        we_d   = state_d == WRITE;
        re_d   = state_d == READ;
        ack1_d = state_d == ACK && !src_d;
        ack2_d = state_d == ACK && src_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            src_q   <= 1'b0;
            err_q   <= 1'b0;
            errc_q  <= '0;
            txn_q   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            ack1_q  <= 1'b0;
            ack2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            src_q   <= src_d;
            err_q   <= err_d;
            errc_q  <= errc_d;
            txn_q   <= txn_d;
            we_q    <= we_d;
            re_q    <= re_d;
            ack1_q  <= ack1_d;
            ack2_q  <= ack2_d;
        end
    end

    assign write_enable = we_q;
    assign read_enable  = re_q;
    assign wr_data      = wr_q;
    assign src_sel      = src_q;
    assign ack1         = ack1_q;
    assign ack2         = ack2_q;
    assign err_flag     = err_q;
    assign err_count    = errc_q;
    assign txn_count    = txn_q;
endmodule
